// File: rtl/fifo_word_packer.sv
// Byte-FIFO drain that packs entries little-endian into a word, with flush.
// Optional per-byte even parity output when WPACK_PARITY_EN is defined.
module fifo_word_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  output logic                             fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]            fifo_rd_data,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH*WORD_BYTES-1:0] out_data,
  output logic [CNT_W-1:0]                 out_bytes
`ifdef WPACK_PARITY_EN
  ,
  output logic [WORD_BYTES-1:0]            out_parity
`endif
);

  localparam int WW = DATA_WIDTH * WORD_BYTES;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORD_BYTES);

  typedef enum logic {FILL, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] landed;
  logic [CNT_W-1:0] landed_nx;
  logic             pend;
  logic             flush_q;
  logic             fl_any;
  logic             go_hold;
  logic [WW-1:0]    data_q;
  logic [WW-1:0]    data_nx;

  always_comb begin
    fifo_rd_en = rst && (state == FILL) && !fifo_empty
              && (issued < FULL) && !flush_q && !flush;
    landed_nx = landed + CNT_W'(pend);
    data_nx = data_q;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (pend && landed == CNT_W'(i))
        data_nx[i*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
    end
    fl_any = flush_q || flush;
    // a flush waits for any in-flight byte before closing the word
    go_hold = (state == FILL)
           && ((landed_nx == FULL)
            || (fl_any && !pend && landed != '0));
  end

`ifdef WPACK_PARITY_EN
  logic [WORD_BYTES-1:0] par_q;

  function automatic logic [WORD_BYTES-1:0] par_of(
    input logic [WW-1:0] d
  );
    logic [WORD_BYTES-1:0] p;
    for (int i = 0; i < WORD_BYTES; i++)
      p[i] = ^d[i*DATA_WIDTH +: DATA_WIDTH];
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_q <= '0;
    end else if (state == FILL) begin
      par_q <= par_of(data_nx);
    end else if (out_ready) begin
      par_q <= '0;
    end
  end

  assign out_parity = par_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      issued    <= '0;
      landed    <= '0;
      pend      <= 1'b0;
      flush_q   <= 1'b0;
      data_q    <= '0;
      out_valid <= 1'b0;
      out_bytes <= '0;
    end else begin
      unique case (state)
        FILL: begin
          pend   <= fifo_rd_en;
          landed <= landed_nx;
          data_q <= data_nx;
          if (fifo_rd_en)
            issued <= issued + CNT_W'(1);
          if (flush && pend)
            flush_q <= 1'b1;
          if (go_hold) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_bytes <= landed_nx;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_bytes <= '0;
            issued    <= '0;
            landed    <= '0;
            flush_q   <= 1'b0;
            data_q    <= '0;
          end
        end
      endcase
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Randomized bench for fifo_word_packer against a queue-based word model.
// Directed cases pin the model with literal expected words.
module tb_fifo_word_packer;

  localparam int WB = 4;

  logic        clk;
  logic        rst;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
`ifdef WPACK_PARITY_EN
  logic [3:0]  out_parity;
`endif

  fifo_word_packer dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_bytes    (out_bytes)
`ifdef WPACK_PARITY_EN
    ,
    .out_parity   (out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fq[$];
  logic [7:0] m_lanes[$];
  bit         m_hold;
  bit         m_inflight;
  bit         m_flush;
  bit         s_rd;
  bit         s_flush;
  bit         s_ready;
  bit         rd_s;
  bit         exp_rd;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    w = '0;
    foreach (m_lanes[i]) w |= 32'(m_lanes[i]) << (8 * i);
    return w;
  endfunction

  // Reference model: the word is simply the ordered list of landed bytes.
  always @(posedge clk or negedge rst) begin
    bit f;
    if (!rst) begin
      m_hold = 0;
      m_lanes.delete();
      m_inflight = 0;
      m_flush = 0;
    end else if (!m_hold) begin
      f = m_flush || s_flush;
      if (m_inflight) m_lanes.push_back(fifo_rd_data);
      if (m_lanes.size() == WB) m_hold = 1;
      else if (f && !m_inflight && m_lanes.size() > 0) m_hold = 1;
      else if (f && m_inflight) m_flush = 1;
      m_inflight = s_rd;
    end else if (s_ready) begin
      m_hold = 0;
      m_lanes.delete();
      m_flush = 0;
    end
  end

  always @(negedge clk) begin
    exp_rd = rst && !m_hold && !fifo_empty
          && (m_lanes.size() + int'(m_inflight) < WB)
          && !m_flush && !flush;
    s_rd    = exp_rd;
    s_flush = flush;
    s_ready = out_ready;
    rd_s    = fifo_rd_en;
    if (!rst) begin
      check("reset_outputs",
            {fifo_rd_en, out_valid, out_bytes, out_data}, '0);
    end else begin
      check("rd_en", fifo_rd_en, exp_rd);
      check("out_valid", out_valid, m_hold);
      if (m_hold) begin
        check("out_data", out_data, model_word());
        check("out_bytes", out_bytes, m_lanes.size());
`ifdef WPACK_PARITY_EN
        begin
          logic [3:0] p;
          p = '0;
          foreach (m_lanes[i]) p[i] = ^m_lanes[i];
          check("out_parity", out_parity, p);
        end
`endif
      end
    end
  end

  task automatic tick(input bit fl, input bit rdy);
    @(posedge clk);
    #1;
    if (rd_s && fq.size() > 0) fifo_rd_data = fq.pop_front();
    else fifo_rd_data = 8'($urandom);
    fifo_empty = (fq.size() == 0);
    flush = fl;
    out_ready = rdy;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic reset_dut(input bit chk);
    #1;
    rst = 1'b0;
    fq.delete();
    flush = 1'b0;
    push(8'h5A);
    @(negedge clk);
    if (chk) begin
      check("reset_no_pop", fifo_rd_en, 1'b0);
      check("reset_word", {out_valid, out_bytes, out_data}, '0);
    end
    tick(0, 0);
    tick(0, 0);
    fq.delete();
    fifo_empty = 1'b1;
    rst = 1'b1;
  endtask

  task automatic run_until_valid(input bit rdy, input string nm);
    bit got;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick(0, rdy);
      @(negedge clk);
      got = out_valid;
    end
    check(nm, got, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dens;
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    reset_dut(1);

    // full word, ready high
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_until_valid(1, "full_valid");
    check("full_data", out_data, 32'h44332211);
    check("full_bytes", out_bytes, 3'd4);
`ifdef WPACK_PARITY_EN
    check("full_parity", out_parity, 4'b0000);
`endif
    tick(0, 1);
    @(negedge clk);
    check("full_one_cycle", out_valid, 1'b0);

    // backpressure
    reset_dut(0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run_until_valid(0, "bp_valid");
    push(8'h77);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0);
      @(negedge clk);
      check("bp_no_pop", fifo_rd_en, 1'b0);
      check("bp_stable", {out_valid, out_data}, {1'b1, 32'h44332211});
    end
    tick(0, 1);
    @(negedge clk);
    tick(0, 0);
    @(negedge clk);
    check("bp_released", out_valid, 1'b0);
    check("bp_resume_pop", fifo_rd_en, 1'b1);

    // partial flush
    reset_dut(0);
    push(8'hA5); push(8'h01);
    repeat (4) tick(0, 1);
    tick(1, 1);
    run_until_valid(1, "pf_valid");
    check("pf_data", out_data, 32'h000001A5);
    check("pf_bytes", out_bytes, 3'd2);
`ifdef WPACK_PARITY_EN
    check("pf_parity", out_parity, 4'b0010);
`endif

    // flush with the third byte in flight
    reset_dut(0);
    push(8'h10); push(8'h20); push(8'h30); push(8'h40);
    tick(0, 1);
    tick(0, 1);
    tick(1, 1);
    @(negedge clk);
    check("fif_no_pop_c3", fifo_rd_en, 1'b0);
    tick(0, 1);
    @(negedge clk);
    check("fif_no_pop_c4", {fifo_rd_en, out_valid}, 2'b00);
    tick(0, 1);
    @(negedge clk);
    check("fif_valid", out_valid, 1'b1);
    check("fif_bytes", out_bytes, 3'd3);
    check("fif_data", out_data, 32'h00302010);

    // reset with two bytes landed
    reset_dut(0);
    push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
    repeat (3) tick(0, 1);
    reset_dut(0);
    push(8'hDE); push(8'hAD); push(8'hBE); push(8'hEF);
    run_until_valid(1, "mr_valid");
    check("mr_data", out_data, 32'hEFBEADDE);
    check("mr_bytes", out_bytes, 3'd4);

    // randomized traffic
    dens = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) dens = $urandom_range(0, 4);
      if ($urandom_range(0, 699) == 0) begin
        reset_dut(0);
      end else begin
        tick($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        if (fq.size() < 12 && $urandom_range(0, 3) < dens)
          push(8'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
